// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types for the sprite ROM read arbiter: ROM geometry, palette pixel
// and the per-stage read pipeline record.
package sprite_rom_pkg;
    localparam int ROM_ADDR_W   = 16;
    localparam int PIX_W        = 2;
    localparam int ROM_MAX_ADDR = 36000;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [1:0]       req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
        logic     oor;
    } rd_stage_t;
endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Combinational round-robin picker: search starts one past the last winner.
module rr_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output req_idx_t           o_idx,
    output logic               o_any
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = IW'((int'(i_last) + k) % NUM_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = req_idx_t'(w_pos);
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM among NUM_REQ fetchers, one read per
// clock, with tagged two-cycle responses and out-of-range interception.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_ADDR = ROM_MAX_ADDR
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ROM_ADDR_W-1:0] i_addr,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output pix_t                          o_rdata,
    output logic                          o_rerr,
    output logic [ROM_ADDR_W-1:0]         o_ram_addr,
    input  pix_t                          i_ram_data
);
    localparam logic [ROM_ADDR_W-1:0] MAX_A = ROM_ADDR_W'(MAX_ADDR);

    req_idx_t              r_last;
    logic [ROM_ADDR_W-1:0] r_ram_addr;
    rd_stage_t             r_s1;
    rd_stage_t             r_s2;
    pix_t                  r_rdata;

    logic [NUM_REQ-1:0]    w_req;
    logic [NUM_REQ-1:0]    w_gnt;
    req_idx_t              w_idx;
    logic                  w_any;
    logic [ROM_ADDR_W-1:0] w_waddr;
    logic                  w_oor;

    // Requests asserted while reset is held must not produce a grant.
    assign w_req = i_req & {NUM_REQ{i_rst_n}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Idle cycles keep the previous ROM address so the bus does not toggle.
    always_comb begin
        w_waddr = r_ram_addr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_waddr = i_addr[i*ROM_ADDR_W +: ROM_ADDR_W];
        end
    end

    assign w_oor      = w_any && (w_waddr > MAX_A);
    assign o_gnt      = w_gnt;
    assign o_ram_addr = w_waddr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last     <= req_idx_t'(NUM_REQ - 1);
            r_ram_addr <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_rdata    <= '0;
        end else begin
            r_ram_addr <= w_waddr;
            if (w_any) r_last <= w_idx;
            r_s1.valid <= w_any;
            r_s1.idx   <= w_idx;
            r_s1.oor   <= w_oor;
            r_s2       <= r_s1;
            r_rdata    <= (r_s1.valid && !r_s1.oor) ? i_ram_data : '0;
        end
    end

    always_comb begin
        o_rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_rvalid[i] = r_s2.valid && (r_s2.idx == req_idx_t'(i));
        end
    end

    assign o_rdata = r_rdata;
    assign o_rerr  = r_s2.valid & r_s2.oor;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (2-requester and 4-requester builds).
module tb_sprite_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [31:0] addr = '0;
    logic [1:0]  gnt, rvalid, rdata;
    logic        rerr;
    logic [15:0] ram_addr;
    logic [1:0]  rom_q = '0;

    logic [3:0]  req4 = '0;
    logic [63:0] addr4 = '0;
    logic [3:0]  gnt4, rvalid4;
    logic [1:0]  rdata4;
    logic        rerr4;
    logic [15:0] ram_addr4;
    logic [1:0]  rom4_q = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] rom(input logic [15:0] a);
        return a[2:1] ^ a[9:8] ^ {a[15], 1'b0};
    endfunction

    always @(posedge clk) rom_q  <= rom(ram_addr);
    always @(posedge clk) rom4_q <= rom(ram_addr4);

    sprite_rom_arbiter #(.NUM_REQ(2), .MAX_ADDR(36000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_rerr(rerr),
        .o_ram_addr(ram_addr), .i_ram_data(rom_q)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .MAX_ADDR(36000)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req4), .i_addr(addr4),
        .o_gnt(gnt4), .o_rvalid(rvalid4), .o_rdata(rdata4), .o_rerr(rerr4),
        .o_ram_addr(ram_addr4), .i_ram_data(rom4_q)
    );

    always @(negedge clk) begin
        assert ($onehot0(gnt4)) else $error("gnt4 not one-hot: %b", gnt4);
        assert ($onehot0(gnt))  else $error("gnt not one-hot: %b", gnt);
    end

    task automatic step(input logic [1:0] rq, input logic [15:0] a1, input logic [15:0] a0);
        @(posedge clk); #1;
        req  = rq;
        addr = {a1, a0};
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0; req4 = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; addr = {16'd7, 16'd5}; req4 = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== 2'b00)     begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
        checks++; if (rvalid !== 2'b00)  begin errors++; $display("FAIL reset_rvalid got %b want 00", rvalid); end
        checks++; if ({rdata, rerr} !== 3'b000) begin errors++; $display("FAIL reset_rdata got %b/%b want 00/0", rdata, rerr); end
        checks++; if (ram_addr !== 16'd0) begin errors++; $display("FAIL reset_ram_addr got %h want 0000", ram_addr); end
        checks++; if (gnt4 !== 4'h0)     begin errors++; $display("FAIL reset_gnt4 got %b want 0000", gnt4); end
        req = '0; req4 = '0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step((c == 0) ? 2'b01 : 2'b00, 16'd0, 16'h0005);
            checks++;
            if (gnt !== ((c == 0) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_gnt c%0d got %b", c, gnt); end
            if (c == 0) begin
                checks++; if (ram_addr !== 16'h0005) begin errors++; $display("FAIL single_ram_addr got %h want 0005", ram_addr); end
            end
            checks++;
            if (c == 2) begin
                if ({rvalid, rdata, rerr} !== {2'b01, 2'b10, 1'b0}) begin
                    errors++; $display("FAIL single_resp got rv=%b rd=%b err=%b want 01/10/0", rvalid, rdata, rerr);
                end
            end else if (rvalid !== 2'b00) begin
                errors++; $display("FAIL single_idle_rv c%0d got %b want 00", c, rvalid);
            end
        end
        checks++; if (ram_addr !== 16'h0005) begin errors++; $display("FAIL single_addr_hold got %h want 0005", ram_addr); end
    endtask

    task automatic test_contention();
        logic [1:0] eg, erv, erd;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step((c < 6) ? 2'b11 : 2'b00, 16'd20, 16'd10);
            eg = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL cont_gnt c%0d got %b want %b", c, gnt, eg); end
            erv = (c < 2) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            erd = (c < 2) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if ({rvalid, rdata, rerr} !== {erv, erd, 1'b0}) begin
                errors++; $display("FAIL cont_resp c%0d got %b/%b/%b want %b/%b/0", c, rvalid, rdata, rerr, erv, erd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] erd;
        for (int c = 0; c < 12; c++) begin
            step((c < 10) ? 2'b10 : 2'b00, 16'(100 + c), 16'd0);
            if (c < 10) begin
                checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_gnt c%0d got %b want 10", c, gnt); end
            end
            if (c >= 2) begin
                erd = rom(16'(100 + c - 2));
                checks++;
                if ({rvalid, rdata, rerr} !== {2'b10, erd, 1'b0}) begin
                    errors++; $display("FAIL b2b_resp c%0d got %b/%b/%b want 10/%b/0", c, rvalid, rdata, rerr, erd);
                end
            end
        end
        step(2'b00, 16'd0, 16'd0);
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL b2b_end got %b want 00", rvalid); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] av [3];
        logic [2:0]  ex [3];
        av[0] = 16'd36001; av[1] = 16'hFFFF; av[2] = 16'd36000;
        ex[0] = 3'b001;    ex[1] = 3'b001;   ex[2] = {2'b10, 1'b0};
        for (int c = 0; c < 5; c++) begin
            step((c < 3) ? 2'b01 : 2'b00, 16'd0, (c < 3) ? av[c] : 16'd0);
            if (c < 3) begin
                checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL oor_gnt c%0d got %b want 01", c, gnt); end
            end
            if (c >= 2) begin
                checks++;
                if ({rvalid, rdata, rerr} !== {2'b01, ex[c-2]}) begin
                    errors++; $display("FAIL oor_resp c%0d got %b/%b/%b want 01/%b", c, rvalid, rdata, rerr, ex[c-2]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(2'b01, 16'd0, 16'd5);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_gnt got %b want 01", gnt); end
        @(posedge clk); #1;
        rst_n = 1'b0; req = 2'b11;
        @(negedge clk);
        checks++;
        if ({gnt, rvalid, rdata, rerr} !== 7'd0 || ram_addr !== 16'd0) begin
            errors++; $display("FAIL mid_reset_outs got g=%b rv=%b rd=%b e=%b a=%h want all 0", gnt, rvalid, rdata, rerr, ram_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req = 2'b11;
        @(negedge clk);
        checks++; if (gnt !== 2'b01)   begin errors++; $display("FAIL mid_first_gnt got %b want 01", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL mid_drop0 got %b want 00", rvalid); end
        step(2'b00, 16'd0, 16'd0);
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL mid_drop1 got %b want 00", rvalid); end
        step(2'b00, 16'd0, 16'd0);
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL mid_new_resp got %b want 01", rvalid); end
    endtask

    task automatic test_four_req();
        logic [3:0] eg [5];
        eg[0] = 4'b0100; eg[1] = 4'b1000; eg[2] = 4'b0001; eg[3] = 4'b0010; eg[4] = 4'b0100;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            req4  = (c == 0) ? 4'b0100 : ((c < 5) ? 4'b1111 : 4'b0000);
            addr4 = {16'd40, 16'd30, 16'd20, 16'd10};
            @(negedge clk);
            if (c < 5) begin
                checks++; if (gnt4 !== eg[c]) begin errors++; $display("FAIL rr4_gnt c%0d got %b want %b", c, gnt4, eg[c]); end
            end
            if (c >= 2) begin
                checks++; if (rvalid4 !== eg[c-2]) begin errors++; $display("FAIL rr4_rv c%0d got %b want %b", c, rvalid4, eg[c-2]); end
            end
        end
        req4 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_out_of_range();
        test_reset_midflight();
        test_four_req();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
